// File: rtl/jogo_pkg.sv
// Shared definitions for the game input path: FSM state codes, the default
// debounce length and the one-hot priority helper.
package jogo_pkg;

    localparam logic [2:0] EST_OCIOSO      = 3'd0;
    localparam logic [2:0] EST_FILTRANDO   = 3'd1;
    localparam logic [2:0] EST_PULSO       = 3'd2;
    localparam logic [2:0] EST_PRESSIONADO = 3'd3;
    localparam logic [2:0] EST_SOLTANDO    = 3'd4;

    typedef enum logic [2:0] {
        OCIOSO      = EST_OCIOSO,
        FILTRANDO   = EST_FILTRANDO,
        PULSO       = EST_PULSO,
        PRESSIONADO = EST_PRESSIONADO,
        SOLTANDO    = EST_SOLTANDO
    } estado_t;

    // 1 ms at 50 MHz
    localparam int DEBOUNCE_1MS_50MHZ = 50000;

    // Keeps only the lowest-index set bit (two's-complement isolate).
    function automatic logic [31:0] one_hot_prioridade(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-stage flip-flop synchroniser for asynchronous level inputs, any width.
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] estagio1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estagio1 <= '0;
            q        <= '0;
        end else begin
            estagio1 <= d;
            q        <= estagio1;
        end
    end

endmodule

// File: rtl/condicionador_jogada.sv
// Button conditioner: synchronise, debounce press and release, emit one jogada
// pulse per press. Define JOGADA_REJEITA_MULTIPLO_EN to reject multi-button presses.
module condicionador_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_1MS_50MHZ
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_valor,
    output logic                multiplo,
    output logic [2:0]          db_estado
);

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    estado_t             estado;
    logic [CW-1:0]       contador;
    logic [N_BOTOES-1:0] sinc;
    logic [N_BOTOES-1:0] amostra;
    logic [N_BOTOES-1:0] valor_resolvido;

    sincronizador_2ff #(
        .LARGURA (N_BOTOES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (sinc)
    );

    // amostra keeps the raw pattern so FILTRANDO compares against what is really held
    assign valor_resolvido = N_BOTOES'(one_hot_prioridade(32'(amostra)));
    assign db_estado       = estado;

`ifdef JOGADA_REJEITA_MULTIPLO_EN
    logic multiplo_q;
    logic multiplos_bits;

    assign multiplos_bits = (amostra & (amostra - N_BOTOES'(1))) != '0;
    assign multiplo       = multiplo_q;
`else
    assign multiplo = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= OCIOSO;
            contador     <= '0;
            amostra      <= '0;
            jogada       <= 1'b0;
            jogada_valor <= '0;
`ifdef JOGADA_REJEITA_MULTIPLO_EN
            multiplo_q   <= 1'b0;
`endif
        end else begin
            jogada <= 1'b0;
`ifdef JOGADA_REJEITA_MULTIPLO_EN
            multiplo_q <= 1'b0;
`endif
            case (estado)
                OCIOSO: begin
                    if (habilita && (sinc != '0)) begin
                        amostra  <= sinc;
                        contador <= '0;
                        estado   <= FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (!habilita || (sinc != amostra)) begin
                        contador <= '0;
                        estado   <= OCIOSO;
                    end else if (contador == CONT_MAX) begin
                        contador <= '0;
                        estado   <= PULSO;
`ifdef JOGADA_REJEITA_MULTIPLO_EN
                        if (multiplos_bits) begin
                            multiplo_q <= 1'b1;
                        end else begin
                            jogada       <= 1'b1;
                            jogada_valor <= valor_resolvido;
                        end
`else
                        jogada       <= 1'b1;
                        jogada_valor <= valor_resolvido;
`endif
                    end else begin
                        contador <= contador + CW'(1);
                    end
                end
                PULSO: begin
                    contador <= '0;
                    estado   <= PRESSIONADO;
                end
                PRESSIONADO: begin
                    if (sinc == '0) begin
                        contador <= '0;
                        estado   <= SOLTANDO;
                    end
                end
                SOLTANDO: begin
                    // any re-press during release restarts the release filter
                    if (sinc != '0) begin
                        contador <= '0;
                        estado   <= PRESSIONADO;
                    end else if (contador == CONT_MAX) begin
                        contador <= '0;
                        estado   <= OCIOSO;
                    end else begin
                        contador <= contador + CW'(1);
                    end
                end
                default: begin
                    contador <= '0;
                    estado   <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_condicionador_jogada.sv
// Bench for condicionador_jogada with a short debounce; honours
// JOGADA_REJEITA_MULTIPLO_EN in its model and directed expectations.
module tb_condicionador_jogada;

    localparam int N = 4;
    localparam int D = 4;

    logic         clock;
    logic         reset;
    logic         habilita;
    logic [N-1:0] botoes;
    logic         jogada;
    logic [N-1:0] jogada_valor;
    logic         multiplo;
    logic [2:0]   db_estado;

    int checks = 0;
    int erros  = 0;
    int n_jog  = 0;
    int n_mult = 0;

    condicionador_jogada #(
        .N_BOTOES        (N),
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .habilita     (habilita),
        .botoes       (botoes),
        .jogada       (jogada),
        .jogada_valor (jogada_valor),
        .multiplo     (multiplo),
        .db_estado    (db_estado)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: real=timeout esperado=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic verifica(input string nome, input logic [31:0] real_v, input logic [31:0] esperado);
        checks++;
        if (real_v !== esperado) begin
            erros++;
            $display("FAIL %s: real=%0h esperado=%0h t=%0t", nome, real_v, esperado, $time);
        end
    endtask

    // behavioural model: stable-run counting on the synchronised buttons
    logic [N-1:0] m_s1, m_s2, m_val, m_jv;
    int           m_run, m_rel;
    bit           m_armado, m_em_pulso, m_jog, m_mult;

    task automatic modelo_reset();
        m_s1 = '0; m_s2 = '0; m_val = '0; m_jv = '0;
        m_run = 0; m_rel = 0;
        m_armado = 1; m_em_pulso = 0; m_jog = 0; m_mult = 0;
    endtask

    task automatic modelo_aceita();
        int bits;
        int baixo;
        bits  = 0;
        baixo = 0;
        for (int i = 0; i < N; i++) bits += int'(m_val[i]);
        for (int i = N - 1; i >= 0; i--) if (m_val[i]) baixo = i;
        m_armado   = 0;
        m_em_pulso = 1;
        m_run      = 0;
`ifdef JOGADA_REJEITA_MULTIPLO_EN
        if (bits > 1) begin
            m_mult = 1;
        end else begin
            m_jog = 1;
            m_jv  = '0;
            m_jv[baixo] = 1'b1;
        end
`else
        m_jog = 1;
        m_jv  = '0;
        m_jv[baixo] = 1'b1;
`endif
    endtask

    task automatic modelo_passo(input bit hab, input logic [N-1:0] b);
        logic [N-1:0] s;
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        m_jog  = 0;
        m_mult = 0;
        if (m_em_pulso) begin
            m_em_pulso = 0;
            m_rel      = 0;
        end else if (!m_armado) begin
            if (s != '0) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel == D + 1) begin
                    m_armado = 1;
                    m_rel    = 0;
                    m_run    = 0;
                end
            end
        end else begin
            if (!hab || s == '0) m_run = 0;
            else if (m_run == 0) begin
                m_run = 1;
                m_val = s;
            end else if (s != m_val) m_run = 0;
            else begin
                m_run++;
                if (m_run == D + 1) modelo_aceita();
            end
        end
    endtask

    function automatic logic [2:0] modelo_estado();
        if (m_em_pulso) return 3'd2;
        if (!m_armado) return (m_rel > 0) ? 3'd4 : 3'd3;
        return (m_run > 0) ? 3'd1 : 3'd0;
    endfunction

    // scoreboard: compare every cycle, 1 time unit after the rising edge
    initial begin
        modelo_reset();
        forever begin
            @(posedge clock);
            #1;
            if (reset) modelo_reset();
            else modelo_passo(habilita, botoes);
            verifica("cmp_jogada", jogada, m_jog);
            verifica("cmp_multiplo", multiplo, m_mult);
            verifica("cmp_valor", jogada_valor, m_jv);
            verifica("cmp_estado", db_estado, modelo_estado());
            if (jogada === 1'b1) n_jog++;
            if (multiplo === 1'b1) n_mult++;
        end
    end

    task automatic apos_borda(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic espera_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // directed vectors
    initial begin
        int n0, nm0;
        reset = 1'b0; habilita = 1'b0; botoes = '0;
        #1 reset = 1'b1;
        apos_borda(2);
        verifica("rst_jogada", jogada, 0);
        verifica("rst_valor", jogada_valor, 0);
        verifica("rst_estado", db_estado, 0);
        verifica("rst_multiplo", multiplo, 0);
        @(negedge clock) reset = 1'b0;

        // clean press
        @(negedge clock);
        habilita = 1'b1; botoes = 4'b0100; n0 = n_jog;
        apos_borda(2);
        verifica("limpo_est_k1", db_estado, 0);
        apos_borda(1);
        verifica("limpo_est_filtrando", db_estado, 1);
        apos_borda(3);
        verifica("limpo_sem_pulso_k5", jogada, 0);
        apos_borda(1);
        verifica("limpo_jogada_k6", jogada, 1);
        verifica("limpo_valor", jogada_valor, 4'b0100);
        verifica("limpo_est_pulso", db_estado, 2);
        apos_borda(1);
        verifica("limpo_jogada_k7", jogada, 0);
        verifica("limpo_est_pressionado", db_estado, 3);
        espera_neg(12);
        botoes = '0;
        apos_borda(3);
        verifica("soltura_est_r2", db_estado, 4);
        apos_borda(3);
        verifica("soltura_est_r5", db_estado, 4);
        apos_borda(1);
        verifica("soltura_est_r6", db_estado, 0);
        verifica("limpo_valor_mantido", jogada_valor, 4'b0100);
        verifica("limpo_n_pulsos", n_jog - n0, 1);

        // bouncing press: on/off every 2 cycles, finally stable on
        @(negedge clock);
        n0 = n_jog; botoes = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            espera_neg(2);
            botoes = botoes ^ 4'b0010;
        end
        verifica("ressalto_sem_pulso", n_jog - n0, 0);
        apos_borda(6);
        verifica("ressalto_sem_pulso_k5", jogada, 0);
        apos_borda(1);
        verifica("ressalto_jogada_k6", jogada, 1);
        verifica("ressalto_valor", jogada_valor, 4'b0010);
        @(negedge clock) botoes = '0;
        espera_neg(12);
        verifica("ressalto_n_pulsos", n_jog - n0, 1);

        // gating by habilita
        @(negedge clock);
        habilita = 1'b0; botoes = 4'b0001; n0 = n_jog;
        apos_borda(10);
        verifica("gate_est_ocioso", db_estado, 0);
        verifica("gate_sem_pulso", n_jog - n0, 0);
        @(negedge clock) habilita = 1'b1;
        apos_borda(1);
        verifica("gate_est_filtrando", db_estado, 1);
        apos_borda(3);
        verifica("gate_sem_pulso_g3", jogada, 0);
        apos_borda(1);
        verifica("gate_jogada_g4", jogada, 1);
        verifica("gate_valor", jogada_valor, 4'b0001);
        @(negedge clock) botoes = '0;
        espera_neg(12);

        // habilita dropped mid-filter
        @(negedge clock);
        botoes = 4'b1000; n0 = n_jog;
        apos_borda(4);
        verifica("aborto_est_filtrando", db_estado, 1);
        @(negedge clock) habilita = 1'b0;
        apos_borda(1);
        verifica("aborto_est_ocioso", db_estado, 0);
        apos_borda(10);
        verifica("aborto_sem_pulso", n_jog - n0, 0);
        verifica("aborto_valor", jogada_valor, 4'b0001);
        @(negedge clock) begin botoes = '0; habilita = 1'b1; end
        espera_neg(8);

        // release with three one-cycle re-presses
        @(negedge clock);
        botoes = 4'b0100; n0 = n_jog;
        apos_borda(7);
        verifica("rel_jogada", jogada, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock) botoes = '0;
            espera_neg(2);
            botoes = 4'b0100;
        end
        @(negedge clock) botoes = '0;
        apos_borda(6);
        verifica("rel_est_f5", db_estado, 4);
        apos_borda(1);
        verifica("rel_est_f6", db_estado, 0);
        verifica("rel_n_pulsos", n_jog - n0, 1);

        // two buttons at once
        @(negedge clock);
        botoes = 4'b0110; n0 = n_jog; nm0 = n_mult;
        apos_borda(7);
`ifdef JOGADA_REJEITA_MULTIPLO_EN
        verifica("mult_multiplo", multiplo, 1);
        verifica("mult_jogada", jogada, 0);
        verifica("mult_valor", jogada_valor, 4'b0100);
`else
        verifica("mult_jogada", jogada, 1);
        verifica("mult_multiplo", multiplo, 0);
        verifica("mult_valor", jogada_valor, 4'b0010);
`endif
        @(negedge clock) botoes = '0;
        espera_neg(12);
`ifdef JOGADA_REJEITA_MULTIPLO_EN
        verifica("mult_n_jog", n_jog - n0, 0);
        verifica("mult_n_mult", n_mult - nm0, 1);
`else
        verifica("mult_n_jog", n_jog - n0, 1);
        verifica("mult_n_mult", n_mult - nm0, 0);
`endif

        // reset mid-filter with the button still held
        @(negedge clock);
        botoes = 4'b0001;
        apos_borda(4);
        verifica("rstm_est_filtrando", db_estado, 1);
        #3 reset = 1'b1;
        #1;
        verifica("rstm_jogada", jogada, 0);
        verifica("rstm_valor", jogada_valor, 0);
        verifica("rstm_estado", db_estado, 0);
        verifica("rstm_multiplo", multiplo, 0);
        espera_neg(2);
        reset = 1'b0;
        n0 = n_jog;
        apos_borda(6);
        verifica("rstm_sem_pulso_k5", jogada, 0);
        apos_borda(1);
        verifica("rstm_jogada_k6", jogada, 1);
        verifica("rstm_valor_k6", jogada_valor, 4'b0001);
        @(negedge clock) botoes = '0;
        espera_neg(12);
        verifica("rstm_n_pulsos", n_jog - n0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule
